// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields plus a 32-bit immediate into an
// instruction word. Two-stage valid/ready pipeline: S1 holds the fields,
// S2 holds the packed word and its range/alignment error flag.
module inst_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);
   localparam int STAGES = 2;

   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_ARI_I  = 5'b00100;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;
   localparam logic [4:0] OP_ARI_R  = 5'b01100;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } fields_t;

   fields_t           s1_q;
   logic [STAGES:1]   vld_pipe;
   logic              s1_load, s2_load, hs;
   logic [31:0]       imm;
   logic [6:0]        opc;
   logic [31:0]       enc_inst;
   logic              enc_err;

   // Each stage advances when empty or when the stage after it moves.
   assign s2_load   = !vld_pipe[2] || out_ready;
   assign s1_load   = !vld_pipe[1] || s2_load;
   assign in_ready  = s1_load && !rst;
   assign out_valid = vld_pipe[2];
   assign hs        = vld_pipe[2] && out_ready;

   assign imm = s1_q.imm;
   assign opc = {s1_q.op, 2'b11};

   // Valid shift register; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         if (s2_load) vld_pipe[2] <= vld_pipe[1];
         if (s1_load) vld_pipe[1] <= in_valid;
      end
   end

   // S1 field capture.
   always_ff @(posedge clk) begin
      if (rst)                       s1_q <= '0;
      else if (s1_load && in_valid)  s1_q <= '{op: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                                               f3: in_funct3, f7: in_funct7, imm: in_imm};
   end

   // Format packing and immediate range check from the S1 fields.
   // Out-of-range immediates are still packed (truncated); only the flag tells.
   always_comb begin
      enc_inst = '0;
      enc_err  = 1'b1;
      unique case (s1_q.op)
         OP_LUI, OP_AUIPC: begin
            enc_inst = {imm[31:12], s1_q.rd, opc};
            enc_err  = imm[11:0] != 12'd0;
         end
         OP_JAL: begin
            enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], s1_q.rd, opc};
            enc_err  = imm[0] || (imm[31:21] != {11{imm[20]}});
         end
         OP_JALR, OP_LOAD, OP_ARI_I: begin
            if (s1_q.op == OP_ARI_I && s1_q.f3[1:0] == 2'b01) begin
               // SLLI/SRLI/SRAI: funct7 selects the shift kind, shamt is 5 bits.
               enc_inst = {s1_q.f7, imm[4:0], s1_q.rs1, s1_q.f3, s1_q.rd, opc};
               enc_err  = imm[31:5] != 27'd0;
            end else begin
               enc_inst = {imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, opc};
               enc_err  = imm[31:12] != {20{imm[11]}};
            end
         end
         OP_BRANCH: begin
            enc_inst = {imm[12], imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3, imm[4:1], imm[11], opc};
            enc_err  = imm[0] || (imm[31:13] != {19{imm[12]}});
         end
         OP_STORE: begin
            enc_inst = {imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, imm[4:0], opc};
            enc_err  = imm[31:12] != {20{imm[11]}};
         end
         OP_SYSTEM: begin
            // CSR address is unsigned; rs1 doubles as zimm for the immediate forms.
            enc_inst = {imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, opc};
            enc_err  = imm[31:12] != 20'd0;
         end
         OP_ARI_R: begin
            enc_inst = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, opc};
            enc_err  = 1'b0;
         end
         default: begin
            enc_inst = '0;
            enc_err  = 1'b1;
         end
      endcase
   end

   // S2 output register; holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_inst <= '0;
         out_err  <= 1'b0;
      end else if (s2_load && vld_pipe[1]) begin
         out_inst <= enc_inst;
         out_err  <= enc_err;
      end
   end

   // Saturating handshake counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (hs) begin
         if (enc_count != '1)            enc_count <= enc_count + CNT_W'(1);
         if (out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
      end
   end

endmodule
